// File: rtl/vga_frame_monitor.sv
// Passive VGA bus sink: recovers pixel coordinates from sync edges, checks timing, streams
// decoded pixels and a per-frame colour checksum. Define BLANK_CHECK_EN to enable err[4].
`timescale 1ns/1ps
module vga_frame_monitor #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned V_TOTAL  = 525
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_pix_en,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic [11:0] i_rgb,
    input  logic        i_clear_err,
    output logic        o_pix_valid,
    output logic [9:0]  o_pix_x,
    output logic [8:0]  o_pix_y,
    output logic [11:0] o_pix_color,
    output logic        o_frame_done,
    output logic [23:0] o_frame_checksum,
    output logic        o_locked,
    output logic [4:0]  o_err
);

    typedef enum logic [1:0] {StSearch, StSync, StLocked} state_e;

    localparam logic [9:0]  H_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0]  H_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0]  V_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
    localparam logic [10:0] H_SW    = 11'(H_SYNC);
    localparam logic [10:0] V_TOT   = 11'(V_TOTAL);
    localparam logic [3:0]  V_SW    = 4'(V_SYNC);

    state_e      r_state, w_state_d;
    logic        r_hs_prev, r_vs_prev;
    logic [9:0]  r_h_cnt, r_v_cnt;
    logic [3:0]  r_vs_lines;
    logic        r_skip_h, r_skip_v, r_frame_err;
    logic [23:0] r_acc;
    logic [4:0]  r_err;
    logic        r_pix_valid, r_frame_done;
    logic [9:0]  r_pix_x;
    logic [8:0]  r_pix_y;
    logic [11:0] r_pix_color;
    logic [23:0] r_checksum;

    logic        w_hs_fall, w_hs_rise, w_vs_fall, w_vs_rise;
    logic [9:0]  w_h_pos, w_v_pos;
    logic        w_armed, w_in_active, w_active;
    logic [4:0]  w_err_set;
    logic        w_err_evt, w_restart, w_done, w_leave_search;

    // w_h_pos/w_v_pos are the coordinates of the sample being taken (post-update counts).
    always_comb begin
        w_hs_fall   = i_pix_en & r_hs_prev & ~i_hsync;
        w_hs_rise   = i_pix_en & ~r_hs_prev & i_hsync;
        w_vs_fall   = i_pix_en & r_vs_prev & ~i_vsync;
        w_vs_rise   = i_pix_en & ~r_vs_prev & i_vsync;
        w_h_pos     = w_hs_fall ? 10'd0 :
                      ((r_h_cnt == 10'h3FF) ? r_h_cnt : r_h_cnt + 10'd1);
        w_v_pos     = w_vs_fall ? 10'd0 : (w_hs_fall ? r_v_cnt + 10'd1 : r_v_cnt);
        w_armed     = (r_state != StSearch);
        w_in_active = (w_h_pos >= H_START) && (w_h_pos < H_END) &&
                      (w_v_pos >= V_START) && (w_v_pos < V_END);
        w_active    = i_pix_en & w_armed & w_in_active;

        w_err_set    = 5'b0;
        w_err_set[0] = w_armed & w_hs_fall & ~r_skip_h & (({1'b0, r_h_cnt} + 11'd1) != H_TOT);
        w_err_set[1] = w_armed & w_hs_rise & (({1'b0, r_h_cnt} + 11'd1) != H_SW);
        w_err_set[2] = w_armed & w_vs_fall & ~r_skip_v & (({1'b0, r_v_cnt} + 11'd1) != V_TOT);
        w_err_set[3] = w_armed & w_vs_rise & (r_vs_lines != V_SW);
`ifdef BLANK_CHECK_EN
        w_err_set[4] = i_pix_en & w_armed & ~w_in_active & (i_rgb != 12'h000);
`endif
        w_err_evt    = |w_err_set;
    end

    always_comb begin
        w_state_d      = r_state;
        w_restart      = 1'b0;
        w_done         = 1'b0;
        w_leave_search = 1'b0;
        unique case (r_state)
            StSearch: begin
                if (w_vs_fall) begin
                    w_state_d      = StSync;
                    w_restart      = 1'b1;
                    w_leave_search = 1'b1;
                end
            end
            StSync: begin
                if (w_vs_fall) begin
                    w_restart = 1'b1;
                    if (!r_frame_err && !w_err_evt) w_state_d = StLocked;
                end
            end
            StLocked: begin
                // An error on the closing vSync fall discards the frame instead of reporting it.
                if (w_err_evt) begin
                    w_state_d = StSync;
                    w_restart = w_vs_fall;
                end else if (w_vs_fall) begin
                    w_done    = 1'b1;
                    w_restart = 1'b1;
                end
            end
            default: w_state_d = StSearch;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= StSearch;
            r_hs_prev    <= 1'b1;
            r_vs_prev    <= 1'b1;
            r_h_cnt      <= 10'd0;
            r_v_cnt      <= 10'd0;
            r_vs_lines   <= 4'd0;
            r_skip_h     <= 1'b0;
            r_skip_v     <= 1'b0;
            r_frame_err  <= 1'b0;
            r_acc        <= 24'd0;
            r_err        <= 5'd0;
            r_pix_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_pix_x      <= 10'd0;
            r_pix_y      <= 9'd0;
            r_pix_color  <= 12'd0;
            r_checksum   <= 24'd0;
        end else begin
            r_state      <= w_state_d;
            r_pix_valid  <= w_active;
            r_frame_done <= w_done;
            r_err        <= (i_clear_err ? 5'd0 : r_err) | w_err_set;
            if (w_done) r_checksum <= r_acc;

            if (w_restart) begin
                r_acc       <= 24'd0;
                r_frame_err <= 1'b0;
            end else begin
                if (w_active) r_acc <= r_acc + {12'd0, i_rgb};
                if (w_err_evt) r_frame_err <= 1'b1;
            end

            if (w_leave_search) begin
                r_skip_h <= 1'b1;
                r_skip_v <= 1'b1;
            end else begin
                if (w_armed && w_hs_fall) r_skip_h <= 1'b0;
                if (w_armed && w_vs_fall) r_skip_v <= 1'b0;
            end

            if (i_pix_en) begin
                r_hs_prev <= i_hsync;
                r_vs_prev <= i_vsync;
                r_h_cnt   <= w_h_pos;
                r_v_cnt   <= w_v_pos;
                if (w_vs_fall) begin
                    r_vs_lines <= {3'd0, w_hs_fall};
                end else if (w_hs_fall && !i_vsync && (r_vs_lines != 4'hF)) begin
                    r_vs_lines <= r_vs_lines + 4'd1;
                end
            end

            if (w_active) begin
                r_pix_x     <= w_h_pos - H_START;
                r_pix_y     <= 9'(w_v_pos - V_START);
                r_pix_color <= i_rgb;
            end
        end
    end

    assign o_pix_valid      = r_pix_valid;
    assign o_pix_x          = r_pix_x;
    assign o_pix_y          = r_pix_y;
    assign o_pix_color      = r_pix_color;
    assign o_frame_done     = r_frame_done;
    assign o_frame_checksum = r_checksum;
    assign o_locked         = (r_state == StLocked);
    assign o_err            = r_err;

endmodule

// File: doc/vga_frame_monitor.md
Name: vga_frame_monitor

Overview:
Passive sink on the VGA output bus (hSync, vSync, 12-bit RGB). It is the receiving end of the VGA timing generator and colour mux. It recovers pixel coordinates from the sync edges, checks 640x480@60 timing, streams decoded pixels and produces a per-frame 24-bit colour checksum. It is used as an on-chip self-check and as the bench's scoreboard front end.

Parameters:
H_ACTIVE, 640, active pixels per line
H_SYNC, 96, hSync low width in pixels
H_BP, 48, back porch in pixels
H_TOTAL, 800, pixels per line
V_ACTIVE, 480, active lines
V_SYNC, 2, vSync low width in lines
V_BP, 33, back porch in lines
V_TOTAL, 525, lines per frame

Ports:
clk  in  1  100 MHz system clock
reset_n  in  1  asynchronous active-low reset
pix_en  in  1  one-cycle strobe, 1 in 4 clk (25 MHz pixel rate); all bus inputs are sampled only when high
hSync  in  1  horizontal sync, active low
vSync  in  1  vertical sync, active low
rgb  in  12  {R,G,B} pixel colour
clear_err  in  1  clears sticky err bits
pix_valid  out  1  one-clk pulse: decoded active pixel
pix_x  out  10  x of decoded pixel, 0..639
pix_y  out  9  y of decoded pixel, 0..479
pix_color  out  12  colour of decoded pixel
frame_done  out  1  one-clk pulse when frame_checksum updates
frame_checksum  out  24  sum of active pixel colours of the last frame
locked  out  1  high in LOCKED
err  out  5  sticky flags: [0] h total, [1] hSync width, [2] v total, [3] vSync width, [4] blank check

Behaviour:
- Reset: all outputs 0, state SEARCH, counters 0, accumulator 0.
- Edge detection uses the previous pix_en sample only. A fall means sampled 1 then 0. A rise means sampled 0 then 1.
- h_cnt (10b): set to 0 on an hSync fall; otherwise increments on each pix_en, saturating at 1023.
- v_cnt (10b): on a vSync fall it is set to 0. Otherwise an hSync fall increments it. If both fall on the same sample, vSync wins.
- Active pixel: h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE), with state not SEARCH.
- On an active sample, pix_valid pulses one clk later. Outputs: pix_x = h_cnt-(H_SYNC+H_BP), pix_y = v_cnt-(V_SYNC+V_BP), pix_color = rgb. These hold until the next active sample.
- Accumulator: 24-bit wrap-around sum of rgb over active samples.
- States:
  - SEARCH: ignores everything except a vSync fall, then moves to SYNC with accumulator cleared and the frame error flag cleared.
  - SYNC: on the next vSync fall, moves to LOCKED if no err bit was set during the frame; otherwise stays in SYNC, restarts the frame and clears the accumulator. No frame_done is issued from SYNC.
  - LOCKED: on each vSync fall, latches the accumulator into frame_checksum, pulses frame_done one clk later and clears the accumulator (the current sample is not added). Any new err bit set moves the state to SYNC on the same clk.
- Checks, armed outside SEARCH:
  - err[0]: set on an hSync fall when h_cnt+1 != H_TOTAL. The first hSync fall after leaving SEARCH is skipped.
  - err[1]: set on an hSync rise when h_cnt+1 != H_SYNC.
  - err[2]: set on a vSync fall when v_cnt+1 != V_TOTAL. The first vSync fall after SEARCH is skipped.
  - err[3]: counts hSync falls while vSync is low; set on a vSync rise when that count != V_SYNC.
- err bits are sticky until clear_err is asserted. If clear_err and a new error occur on the same clk, the error wins.
- Reset asserted mid-frame: immediate return to SEARCH; pulses in flight are dropped.

Optional Feature:
BLANK_CHECK_EN
- Defined: err[4] is set when any sample outside the active region, outside SEARCH, has rgb != 0.
- Undefined: err[4] is tied 0 and the compare logic is absent.

Test Plan:
- Ideal 640x480 timing from the existing generator, rgb = 0, 3 frames -> locked rises at the 2nd vSync fall; frame_done on the 3rd with frame_checksum = 0x000000; err = 0.
- Solid rgb = 12'hFFF in the active region -> frame_checksum = 0xFB5000. 307200 pix_valid pulses per frame; first pulse x=0,y=0, last x=639,y=479.
- One line shortened to 799 pixels while LOCKED -> err[0] = 1, locked drops the same clk, no frame_done for that frame; with good timing and clear_err, re-locks after one full frame.
- hSync low width 95 -> err[1] = 1; vSync low 3 lines -> err[3] = 1; 526-line frame -> err[2] = 1.
- reset_n pulsed low mid-line -> all outputs 0 asynchronously; locked returns only after two vSync falls.
- With BLANK_CHECK_EN, rgb = 12'h001 at h_cnt = 10 -> err[4] = 1; without the macro -> err[4] stays 0.
